// File: rtl/multicycle_controller_if.sv
// Shared instruction/data memory port of the multicycle controller.
// The controller is the master: it raises mem_req together with the address
// select and strobe, and the memory answers with mem_ack.
interface multicycle_controller_if;
    logic mem_req;
    logic mem_ack;
    logic IorD;
    logic MemRead;
    logic MemWrite;

    modport master (
        output mem_req,
        output IorD,
        output MemRead,
        output MemWrite,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  IorD,
        input  MemRead,
        input  MemWrite,
        output mem_ack
    );
endinterface

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multicycle MIPS core. Outputs are decoded from the
// current state plus OpCode/Funct/Zero. Memory accesses use a req/ack
// handshake guarded by a wait-state watchdog that parks the FSM in S_HALT.
module multicycle_controller #(
    parameter int WAIT_MAX = 255,
    parameter int CNT_W    = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_controller_if.master mem,
    input  logic [5:0]              OpCode,
    input  logic [5:0]              Funct,
    input  logic                    Zero,
    output logic                    IRWrite,
    output logic                    PCWrite,
    output logic [1:0]              PCSource,
    output logic [1:0]              ALUSrcA,
    output logic [1:0]              ALUSrcB,
    output logic [2:0]              ALUOp,
    output logic                    ExtOp,
    output logic                    LuOp,
    output logic                    RegWrite,
    output logic [1:0]              RegDst,
    output logic [1:0]              MemtoReg,
    output logic                    instr_retired,
    output logic                    illegal,
    output logic                    halted
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_RTEX,
        S_RTWB, S_BRANCH, S_IEX, S_IWB, S_JUMP, S_JR, S_HALT
    } state_t;

    // Count value at which the cycle still waiting is the last one allowed.
    localparam logic [CNT_W-1:0] WD_LAST = (WAIT_MAX > 0) ? CNT_W'(WAIT_MAX - 1) : '0;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] wait_cnt;
    logic             req;
    logic             ack;
    logic             wd_trip;

    function automatic logic r_funct_legal(input logic [5:0] f);
        return (f inside {6'h00, 6'h02, 6'h03, 6'h08, 6'h09, 6'h2a, 6'h2b}) ||
               (f >= 6'h20 && f <= 6'h27);
    endfunction

    // Memory is requested in the three access states; reset kills it at once.
    assign req     = reset && (state inside {S_FETCH, S_MEMRD, S_MEMWR});
    assign ack     = req && mem.mem_ack;
    assign wd_trip = (WAIT_MAX > 0) && req && !mem.mem_ack && (wait_cnt == WD_LAST);

    // State register and wait-state counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            state <= next_state;
            if (req && !mem.mem_ack) wait_cnt <= wait_cnt + 1'b1;
            else                     wait_cnt <= '0;
        end
    end

    // Next-state selection, with the watchdog overriding any waiting state.
    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:  if (ack) next_state = S_DECODE;
            S_DECODE: begin
                case (OpCode)
                    6'h00: begin
                        if (Funct == 6'h08 || Funct == 6'h09) next_state = S_JR;
                        else if (r_funct_legal(Funct))        next_state = S_RTEX;
                        else                                  next_state = S_FETCH;
                    end
                    6'h23, 6'h2b: next_state = S_MEMADR;
                    6'h04, 6'h05: next_state = S_BRANCH;
                    6'h02, 6'h03: next_state = S_JUMP;
                    6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0f: next_state = S_IEX;
                    default:      next_state = S_FETCH;
                endcase
            end
            S_MEMADR: next_state = (OpCode == 6'h23) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (ack) next_state = S_MEMWB;
            S_MEMWB:  next_state = S_FETCH;
            S_MEMWR:  if (ack) next_state = S_FETCH;
            S_RTEX:   next_state = S_RTWB;
            S_RTWB:   next_state = S_FETCH;
            S_BRANCH: next_state = S_FETCH;
            S_IEX:    next_state = S_IWB;
            S_IWB:    next_state = S_FETCH;
            S_JUMP:   next_state = S_FETCH;
            S_JR:     next_state = S_FETCH;
            S_HALT:   next_state = S_HALT;
            default:  next_state = S_FETCH;
        endcase
        if (wd_trip) next_state = S_HALT;
    end

    // Control decode; everything not named for a state stays 0, and all is 0 in reset.
    always_comb begin
        mem.mem_req   = req;
        mem.IorD      = 1'b0;
        mem.MemRead   = 1'b0;
        mem.MemWrite  = 1'b0;
        IRWrite       = 1'b0;
        PCWrite       = 1'b0;
        PCSource      = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        ALUOp         = 3'b000;
        ExtOp         = 1'b0;
        LuOp          = 1'b0;
        RegWrite      = 1'b0;
        RegDst        = 2'b00;
        MemtoReg      = 2'b00;
        instr_retired = 1'b0;
        illegal       = 1'b0;
        halted        = 1'b0;
        if (reset) begin
            case (state)
                S_FETCH: begin
                    mem.MemRead = 1'b1;
                    ALUSrcB     = 2'b01;
                    IRWrite     = ack;
                    PCWrite     = ack;
                end
                S_DECODE: begin
                    ALUSrcB = 2'b11;
                    ExtOp   = 1'b1;
                    illegal = (next_state == S_FETCH);
                end
                S_MEMADR: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b10;
                    ExtOp   = 1'b1;
                end
                S_MEMRD: begin
                    mem.MemRead = 1'b1;
                    mem.IorD    = 1'b1;
                end
                S_MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 2'b01;
                end
                S_MEMWR: begin
                    mem.MemWrite = 1'b1;
                    mem.IorD     = 1'b1;
                end
                S_RTEX: begin
                    ALUSrcA = (Funct inside {6'h00, 6'h02, 6'h03}) ? 2'b10 : 2'b01;
                    ALUOp   = 3'b010;
                end
                S_RTWB: begin
                    RegWrite = 1'b1;
                    RegDst   = 2'b01;
                end
                S_BRANCH: begin
                    ALUSrcA  = 2'b01;
                    ALUOp    = 3'b001;
                    PCSource = 2'b01;
                    PCWrite  = (OpCode == 6'h04) ? Zero : !Zero;
                end
                S_IEX: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b10;
                    case (OpCode)
                        6'h08, 6'h09: ExtOp = 1'b1;
                        6'h0a: begin ALUOp = 3'b101; ExtOp = 1'b1; end
                        6'h0b: begin ALUOp = 3'b110; ExtOp = 1'b1; end
                        6'h0c: ALUOp = 3'b011;
                        6'h0d: ALUOp = 3'b100;
                        6'h0f: begin ALUSrcA = 2'b11; LuOp = 1'b1; end
                        default: ;
                    endcase
                end
                S_IWB: RegWrite = 1'b1;
                S_JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                    if (OpCode == 6'h03) begin
                        RegWrite = 1'b1;
                        RegDst   = 2'b10;
                        MemtoReg = 2'b10;
                    end
                end
                S_JR: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b11;
                    if (Funct == 6'h09) begin
                        RegWrite = 1'b1;
                        RegDst   = 2'b01;
                        MemtoReg = 2'b10;
                    end
                end
                S_HALT: halted = 1'b1;
                default: ;
            endcase
            // Decode and fetch never finish an instruction; illegal exits come from decode.
            instr_retired = (next_state == S_FETCH) && !(state inside {S_FETCH, S_DECODE});
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller. A reference model expands
// each instruction into its expected per-cycle control words from the
// instruction class rules, and every cycle is compared against the DUT.
module tb_multicycle_controller;

    typedef struct packed {
        logic       mem_req, IorD, MemRead, MemWrite, IRWrite, PCWrite;
        logic [1:0] PCSource, ALUSrcA, ALUSrcB;
        logic [2:0] ALUOp;
        logic       ExtOp, LuOp, RegWrite;
        logic [1:0] RegDst, MemtoReg;
        logic       instr_retired, illegal, halted;
    } ctl_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] OpCode = '0, Funct = '0;
    logic       Zero = 1'b0;
    logic       IRWrite, PCWrite, ExtOp, LuOp, RegWrite, instr_retired, illegal, halted;
    logic [1:0] PCSource, ALUSrcA, ALUSrcB, RegDst, MemtoReg;
    logic [2:0] ALUOp;

    int checks = 0;
    int errors = 0;

    ctl_t exp_q[$];
    logic ack_q[$];
    logic fetch_q[$];

    multicycle_controller_if mif();

    multicycle_controller #(.WAIT_MAX(4), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .mem(mif),
        .OpCode(OpCode), .Funct(Funct), .Zero(Zero),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSource(PCSource),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .ExtOp(ExtOp), .LuOp(LuOp), .RegWrite(RegWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .instr_retired(instr_retired),
        .illegal(illegal), .halted(halted)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete, got running required finished");
        $fatal(1, "timeout");
    end

    function automatic ctl_t observe();
        ctl_t o;
        o = '0;
        o.mem_req = mif.mem_req; o.IorD = mif.IorD; o.MemRead = mif.MemRead;
        o.MemWrite = mif.MemWrite; o.IRWrite = IRWrite; o.PCWrite = PCWrite;
        o.PCSource = PCSource; o.ALUSrcA = ALUSrcA; o.ALUSrcB = ALUSrcB;
        o.ALUOp = ALUOp; o.ExtOp = ExtOp; o.LuOp = LuOp; o.RegWrite = RegWrite;
        o.RegDst = RegDst; o.MemtoReg = MemtoReg; o.instr_retired = instr_retired;
        o.illegal = illegal; o.halted = halted;
        return o;
    endfunction

    function automatic ctl_t fetch_wait_word();
        ctl_t e;
        e = '0; e.mem_req = 1'b1; e.MemRead = 1'b1; e.ALUSrcB = 2'b01;
        return e;
    endfunction

    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00)
            return (fn inside {6'h00, 6'h02, 6'h03, 6'h08, 6'h09, 6'h2a, 6'h2b}) ||
                   (fn >= 6'h20 && fn <= 6'h27);
        return op inside {6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h03,
                          6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0f};
    endfunction

    task automatic push(input ctl_t e, input logic ack_when_req, input logic is_fetch);
        exp_q.push_back(e);
        ack_q.push_back(e.mem_req ? ack_when_req : 1'($urandom));
        fetch_q.push_back(is_fetch);
    endtask

    // Expand one instruction into its expected cycle sequence.
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                         input int wf, input int wm);
        ctl_t e;
        exp_q.delete(); ack_q.delete(); fetch_q.delete();
        for (int i = 0; i <= wf; i++) begin
            e = fetch_wait_word();
            if (i == wf) begin e.IRWrite = 1'b1; e.PCWrite = 1'b1; end
            push(e, i == wf, 1'b1);
        end
        e = '0; e.ALUSrcB = 2'b11; e.ExtOp = 1'b1;
        if (!is_legal(op, fn)) begin
            e.illegal = 1'b1;
            push(e, 1'b0, 1'b0);
            return;
        end
        push(e, 1'b0, 1'b0);
        e = '0;
        if (op == 6'h00 && (fn == 6'h08 || fn == 6'h09)) begin
            e.PCWrite = 1'b1; e.PCSource = 2'b11;
            if (fn == 6'h09) begin e.RegWrite = 1'b1; e.RegDst = 2'b01; e.MemtoReg = 2'b10; end
            push(e, 1'b0, 1'b0);
        end else if (op == 6'h00) begin
            e.ALUSrcA = (fn inside {6'h00, 6'h02, 6'h03}) ? 2'b10 : 2'b01;
            e.ALUOp = 3'b010;
            push(e, 1'b0, 1'b0);
            e = '0; e.RegWrite = 1'b1; e.RegDst = 2'b01;
            push(e, 1'b0, 1'b0);
        end else if (op == 6'h23 || op == 6'h2b) begin
            e.ALUSrcA = 2'b01; e.ALUSrcB = 2'b10; e.ExtOp = 1'b1;
            push(e, 1'b0, 1'b0);
            for (int i = 0; i <= wm; i++) begin
                e = '0; e.mem_req = 1'b1; e.IorD = 1'b1;
                if (op == 6'h23) e.MemRead = 1'b1; else e.MemWrite = 1'b1;
                push(e, i == wm, 1'b0);
            end
            if (op == 6'h23) begin
                e = '0; e.RegWrite = 1'b1; e.MemtoReg = 2'b01;
                push(e, 1'b0, 1'b0);
            end
        end else if (op == 6'h04 || op == 6'h05) begin
            e.ALUSrcA = 2'b01; e.ALUOp = 3'b001; e.PCSource = 2'b01;
            e.PCWrite = (op == 6'h04) ? z : !z;
            push(e, 1'b0, 1'b0);
        end else if (op == 6'h02 || op == 6'h03) begin
            e.PCWrite = 1'b1; e.PCSource = 2'b10;
            if (op == 6'h03) begin e.RegWrite = 1'b1; e.RegDst = 2'b10; e.MemtoReg = 2'b10; end
            push(e, 1'b0, 1'b0);
        end else begin
            e.ALUSrcB = 2'b10;
            e.ALUSrcA = (op == 6'h0f) ? 2'b11 : 2'b01;
            case (op)
                6'h08, 6'h09: e.ExtOp = 1'b1;
                6'h0a: begin e.ALUOp = 3'b101; e.ExtOp = 1'b1; end
                6'h0b: begin e.ALUOp = 3'b110; e.ExtOp = 1'b1; end
                6'h0c: e.ALUOp = 3'b011;
                6'h0d: e.ALUOp = 3'b100;
                default: e.LuOp = 1'b1;
            endcase
            push(e, 1'b0, 1'b0);
            e = '0; e.RegWrite = 1'b1;
            push(e, 1'b0, 1'b0);
        end
        // The last cycle of a legal instruction retires it.
        e = exp_q[exp_q.size() - 1];
        e.instr_retired = 1'b1;
        exp_q[exp_q.size() - 1] = e;
    endtask

    // Play the first n expected cycles (all if n < 0). Entered and left just after a negedge.
    task automatic run(input string name, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input int n);
        ctl_t o;
        int lim;
        lim = (n < 0) ? exp_q.size() : n;
        for (int i = 0; i < lim; i++) begin
            OpCode  = fetch_q[i] ? 6'($urandom) : op;
            Funct   = fetch_q[i] ? 6'($urandom) : fn;
            Zero    = z;
            mif.mem_ack = ack_q[i];
            #1;
            o = observe();
            checks++;
            if (o !== exp_q[i]) begin
                errors++;
                $display("FAIL %s cycle %0d op=%h fn=%h: got %h expected %h",
                         name, i, op, fn, o, exp_q[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        ctl_t o;
        reset = 1'b0;
        mif.mem_ack = 1'b0;
        #1;
        o = observe();
        checks++;
        if (o !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", o, ctl_t'('0));
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Confirm the instruction has ended: the cycle after it is a plain fetch.
    task automatic peek_fetch(input string name);
        ctl_t o;
        mif.mem_ack = 1'b0;
        #1;
        o = observe();
        checks++;
        if (o !== fetch_wait_word()) begin
            errors++;
            $display("FAIL %s_next_fetch: got %h expected %h", name, o, fetch_wait_word());
        end
        @(negedge clk);
        do_reset();
    endtask

    task automatic test_reset();
        ctl_t o;
        @(negedge clk);
        do_reset();
        build(6'h23, 6'h00, 1'b0, 0, 3);
        run("reset_lw_prefix", 6'h23, 6'h00, 1'b0, 4);
        mif.mem_ack = 1'b0;
        #1;
        checks++;
        if (mif.mem_req !== 1'b1) begin
            errors++;
            $display("FAIL reset_memrd_req: got %b expected 1", mif.mem_req);
        end
        reset = 1'b0;
        #1;
        o = observe();
        checks++;
        if (o !== '0) begin
            errors++;
            $display("FAIL reset_mid_access: got %h expected %h", o, ctl_t'('0));
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        o = observe();
        checks++;
        if (o !== fetch_wait_word()) begin
            errors++;
            $display("FAIL reset_release_fetch: got %h expected %h", o, fetch_wait_word());
        end
        @(negedge clk);
        do_reset();
    endtask

    task automatic test_addu();
        build(6'h00, 6'h21, 1'b0, 0, 0);
        run("addu", 6'h00, 6'h21, 1'b0, -1);
        peek_fetch("addu");
    endtask

    task automatic test_lw_wait();
        build(6'h23, 6'h00, 1'b1, 3, 3);
        run("lw_wait3", 6'h23, 6'h00, 1'b1, -1);
        peek_fetch("lw_wait3");
    endtask

    task automatic test_branch();
        build(6'h04, 6'h00, 1'b1, 0, 0);
        run("beq_taken", 6'h04, 6'h00, 1'b1, -1);
        build(6'h05, 6'h00, 1'b1, 0, 0);
        run("bne_not_taken", 6'h05, 6'h00, 1'b1, -1);
        build(6'h05, 6'h00, 1'b0, 1, 0);
        run("bne_taken", 6'h05, 6'h00, 1'b0, -1);
    endtask

    task automatic test_jump_illegal();
        build(6'h03, 6'h00, 1'b0, 0, 0);
        run("jal", 6'h03, 6'h00, 1'b0, -1);
        build(6'h3f, 6'h00, 1'b0, 0, 0);
        run("illegal_op3f", 6'h3f, 6'h00, 1'b0, -1);
        build(6'h00, 6'h01, 1'b0, 0, 0);
        run("illegal_funct01", 6'h00, 6'h01, 1'b0, -1);
        build(6'h00, 6'h09, 1'b0, 2, 0);
        run("jalr", 6'h00, 6'h09, 1'b0, -1);
        build(6'h2b, 6'h00, 1'b0, 0, 0);
        run("sw", 6'h2b, 6'h00, 1'b0, -1);
        peek_fetch("sw");
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops[13] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h03,
                                6'h08, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0f};
        logic [5:0] fns[6]  = '{6'h00, 6'h03, 6'h08, 6'h21, 6'h2a, 6'h27};
        logic [5:0] op, fn;
        logic z;
        for (int k = 0; k < 80; k++) begin
            op = ($urandom_range(0, 9) < 8) ? ops[$urandom_range(0, 12)] : 6'($urandom);
            fn = ($urandom_range(0, 3) < 3) ? fns[$urandom_range(0, 5)] : 6'($urandom);
            z  = 1'($urandom);
            build(op, fn, z, $urandom_range(0, 3), $urandom_range(0, 3));
            run("random", op, fn, z, -1);
        end
        peek_fetch("random");
    endtask

    task automatic test_watchdog();
        ctl_t o, h;
        h = '0; h.halted = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mif.mem_ack = 1'b0;
            #1;
            o = observe();
            checks++;
            if (o !== fetch_wait_word()) begin
                errors++;
                $display("FAIL wd_wait%0d: got %h expected %h", i, o, fetch_wait_word());
            end
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++) begin
            mif.mem_ack = (i != 0);
            OpCode = 6'($urandom);
            #1;
            o = observe();
            checks++;
            if (o !== h) begin
                errors++;
                $display("FAIL wd_halted%0d: got %h expected %h", i, o, h);
            end
            @(negedge clk);
        end
        do_reset();
        build(6'h00, 6'h25, 1'b0, 0, 0);
        run("after_halt_or", 6'h00, 6'h25, 1'b0, -1);
    endtask

    initial begin
        reset = 1'b0;
        mif.mem_ack = 1'b0;
        test_reset();
        test_addu();
        test_lw_wait();
        test_branch();
        test_jump_illegal();
        test_back_to_back();
        test_watchdog();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Sequencing FSM for the multicycle version of the MIPS core. Drives one shared instruction/data memory port, the IR, the PC, the register file, the ALU input muxes and ALUOp.
- Uses a req/ack memory handshake with a wait-state watchdog.
- Replaces the single-cycle combinational Control once PC, IR, A, B, ALUOut and MDR become registers.

Parameters:
- WAIT_MAX, 255: max cycles mem_req may stay high without mem_ack; 0 disables the watchdog.
- CNT_W, 8: wait-counter width; must satisfy 2^CNT_W > WAIT_MAX.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- OpCode  in  6  IR[31:26], valid from S_DECODE onward
- Funct  in  6  IR[5:0]
- Zero  in  1  ALU zero flag
- mem_ack  in  1  memory completes the current access at this edge
- mem_req  out  1  memory access request
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  out  1  read strobe
- MemWrite  out  1  write strobe
- IRWrite  out  1  load IR
- PCWrite  out  1  final PC load enable (unconditional OR branch taken)
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = A (rs)
- ALUSrcA  out  2  00 = PC, 01 = A, 10 = shamt, 11 = zero
- ALUSrcB  out  2  00 = B, 01 = constant 4, 10 = ImmExt, 11 = ImmExtShift
- ALUOp  out  3  000 add, 001 sub, 010 funct-decode, 011 and, 100 or, 101 slt, 110 sltu
- ExtOp  out  1  1 = sign extend, 0 = zero extend
- LuOp  out  1  ImmExt = imm << 16
- RegWrite  out  1  register file write enable
- RegDst  out  2  00 = rt, 01 = rd, 10 = $31
- MemtoReg  out  2  00 = ALUOut, 01 = MDR, 10 = PC
- instr_retired  out  1  one-cycle pulse per completed instruction
- illegal  out  1  one-cycle pulse on an unsupported opcode/funct
- halted  out  1  sticky watchdog-timeout flag

Behaviour:
- Reset: reset low forces state S_FETCH, clears the wait counter and clears halted. All outputs read 0 while reset is low, including mem_req. Reset dropping mid-access drops mem_req immediately.
- Output timing: outputs are combinational decodes of state, OpCode, Funct and Zero (Moore plus branch term). All signals not listed for a state are 0.
- Handshake: mem_req is held high until mem_ack is sampled at a rising edge; that edge completes the access. mem_ack is ignored when mem_req is low. IRWrite and the fetch PCWrite are asserted only in a cycle where mem_ack=1.
- Watchdog: the counter increments each cycle with mem_req=1 and mem_ack=0, and clears on ack.
  - When count reaches WAIT_MAX (WAIT_MAX > 0), the next state is S_HALT.
  - In S_HALT, halted=1 and all other outputs are 0 until reset.
- S_FETCH: mem_req, MemRead, IorD=0, ALUSrcA=00, ALUSrcB=01, PCSource=00. On ack: IRWrite=1, PCWrite=1, go to S_DECODE.
- S_DECODE: ALUSrcA=00, ALUSrcB=11, ExtOp=1, so ALUOut receives the branch target. Next state by opcode:
  - 0x00 → S_RTEX (funct 0x08/0x09 → S_JR)
  - 0x23/0x2b → S_MEMADR
  - 0x04/0x05 → S_BRANCH
  - 0x02/0x03 → S_JUMP
  - 0x08–0x0d, 0x0f → S_IEX
  - anything else → S_FETCH with illegal=1
- Legal R funct codes: 00, 02, 03, 08, 09, 20–27, 2a, 2b. Any other funct goes to S_FETCH with illegal=1. An illegal instruction does not pulse instr_retired.
- S_MEMADR: ALUSrcA=01, ALUSrcB=10, ExtOp=1, ALUOp=000. Next: lw → S_MEMRD, sw → S_MEMWR.
- S_MEMRD: mem_req, MemRead, IorD=1. On ack → S_MEMWB.
- S_MEMWB: RegWrite, RegDst=00, MemtoReg=01 → S_FETCH.
- S_MEMWR: mem_req, MemWrite, IorD=1. On ack → S_FETCH.
- S_RTEX: ALUSrcA=10 for funct 00/02/03, else 01. ALUSrcB=00, ALUOp=010 → S_RTWB.
- S_RTWB: RegWrite, RegDst=01, MemtoReg=00 → S_FETCH.
- S_BRANCH: ALUSrcA=01, ALUSrcB=00, ALUOp=001, PCSource=01. PCWrite = Zero for beq, !Zero for bne → S_FETCH.
- S_IEX: ALUSrcB=10.
  - addi/addiu: ALUOp 000, ExtOp=1.
  - slti: ALUOp 101, ExtOp=1.
  - sltiu: ALUOp 110, ExtOp=1.
  - andi: ALUOp 011, ExtOp=0.
  - ori: ALUOp 100, ExtOp=0.
  - lui: ALUSrcA=11, LuOp=1, ALUOp 000.
  - ALUSrcA=01 except for lui. Next → S_IWB.
- S_IWB: RegWrite, RegDst=00, MemtoReg=00 → S_FETCH.
- S_JUMP: PCWrite, PCSource=10. For jal, also RegWrite, RegDst=10, MemtoReg=10. → S_FETCH.
- S_JR: PCWrite, PCSource=11. For jalr, also RegWrite, RegDst=01, MemtoReg=10. → S_FETCH.
- instr_retired: pulses in the last cycle of an instruction (the cycle whose next state is S_FETCH, excluding illegal and reset).
- Latency with zero wait states: beq/j/jr = 3 cycles; R-type, I-type and sw = 4; lw = 5. Each memory wait cycle adds 1.

Test Plan:
- Reset low mid-S_MEMRD with mem_req=1 → mem_req=0 immediately. After release: S_FETCH, mem_req=1, halted=0.
- addu (op 00, funct 21), ack on first request cycle → exactly 4 cycles; S_RTWB shows RegWrite=1, RegDst=01; one instr_retired pulse.
- lw with 3-cycle ack delay on both accesses → 11 cycles total; IorD=1 only in S_MEMRD; MemtoReg=01 in S_MEMWB.
- beq: Zero=1 → PCWrite=1, PCSource=01. bne with Zero=1 → PCWrite=0 in S_BRANCH.
- jal → S_JUMP with PCWrite=1, PCSource=10, RegDst=10, MemtoReg=10. Opcode 0x3f → illegal pulse, next state S_FETCH, no RegWrite.
- WAIT_MAX=4, mem_ack held 0 → halted=1 after the 4-count is reached; outputs 0 thereafter; a late mem_ack is ignored; only reset clears.
